// File: rtl/shift_rows_pipe.sv
// Pipelined AES/Rijndael ShiftRows / InvShiftRows stage (Nb = 4, 6 or 8) with a 2-entry skid buffer.
// Define SHIFT_ROWS_PIPE_STATS_EN to add the blk_count transfer counter port.
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inverse,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [32*NB-1:0]  in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [32*NB-1:0]  out_state
`ifdef SHIFT_ROWS_PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  blk_count
`endif
);

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (CNT_W < 1) begin : g_bad_cnt
      $error("shift_rows_pipe: CNT_W must be at least 1");
    end
  endgenerate

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [32*NB-1:0] fwd_state;
  logic [32*NB-1:0] inv_state;
  logic [32*NB-1:0] shifted;

  // Source columns are fixed at elaboration, so the permutation is pure wiring.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      localparam int OFF = (NB == 8 && gi >= 2) ? gi + 1 : gi;
      for (gj = 0; gj < NB; gj++) begin : g_col
        localparam int SRC_F = (gj + OFF) % NB;
        localparam int SRC_I = (gj - OFF + NB) % NB;
        assign fwd_state[(gj*4+gi)*8 +: 8] = in_state[(SRC_F*4+gi)*8 +: 8];
        assign inv_state[(gj*4+gi)*8 +: 8] = in_state[(SRC_I*4+gi)*8 +: 8];
      end
    end
  endgenerate

  assign shifted = in_inverse ? inv_state : fwd_state;

  logic [1:0]       state_reg, state_next;
  logic             in_ready_reg;
  logic [32*NB-1:0] head_state_reg, skid_state_reg;
  logic [TAG_W-1:0] head_tag_reg, skid_tag_reg;
  logic             in_fire, out_fire;

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != S_EMPTY);
  assign out_state = head_state_reg;
  assign out_tag   = head_tag_reg;
  assign in_fire   = in_valid & in_ready_reg;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_EMPTY: if (in_fire) state_next = S_ONE;
      S_ONE: begin
        if (in_fire && !out_fire)      state_next = S_FULL;
        else if (!in_fire && out_fire) state_next = S_EMPTY;
      end
      S_FULL:  if (out_fire) state_next = S_ONE;
      default: state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_EMPTY;
      in_ready_reg   <= 1'b0;
      head_state_reg <= '0;
      head_tag_reg   <= '0;
      skid_state_reg <= '0;
      skid_tag_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != S_FULL);
      case (state_reg)
        S_EMPTY: begin
          if (in_fire) begin
            head_state_reg <= shifted;
            head_tag_reg   <= in_tag;
          end
        end
        S_ONE: begin
          // With a simultaneous pop the new entry goes straight to the head.
          if (in_fire && out_fire) begin
            head_state_reg <= shifted;
            head_tag_reg   <= in_tag;
          end else if (in_fire) begin
            skid_state_reg <= shifted;
            skid_tag_reg   <= in_tag;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            head_state_reg <= skid_state_reg;
            head_tag_reg   <= skid_tag_reg;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHIFT_ROWS_PIPE_STATS_EN
  logic [CNT_W-1:0] blk_count_reg;

  always_ff @(posedge clk) begin
    if (rst) blk_count_reg <= '0;
    else if (out_fire) blk_count_reg <= blk_count_reg + 1'b1;
  end

  assign blk_count = blk_count_reg;
`endif

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, pipelined ShiftRows / InvShiftRows stage for the AES/Rijndael datapath.
- Supports block widths of 4, 6 or 8 columns (Rijndael Nb), with the direction selected per transfer.
- Uses valid/ready handshakes on input and output, with a 2-entry skid buffer so full throughput is kept with a registered in_ready.
- Sits between sub_bytes and mix_columns in the iterative round core. A sideband tag travels alongside each state.

Parameters:
- NB, 4, state column count; legal values 4, 6, 8; any other value is an elaboration error.
- TAG_W, 4, width of the sideband tag carried with each state (round number / key slot).
- CNT_W, 32, width of the transfer counter (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input state valid
- in_ready  out  1  stage can accept; registered
- in_inverse  in  1  0 = ShiftRows, 1 = InvShiftRows
- in_tag  in  TAG_W  sideband, passed unchanged
- in_state  in  32*NB  column-major state; byte (row r, col c) at bits [(c*4+r)*8 +: 8]
- out_valid  out  1  output state valid
- out_ready  in  1  downstream accepts
- out_tag  out  TAG_W  tag of the output state
- out_state  out  32*NB  shifted state, same layout as in_state
- blk_count  out  CNT_W  completed transfers (present only with SHIFT_ROWS_PIPE_STATS_EN)

Behaviour:
- Row offsets off[r]:
  - NB=4 or 6: 0,1,2,3.
  - NB=8: 0,1,3,4.
- Forward: out[r][c] = in[r][(c+off[r]) mod NB].
- Inverse: out[r][c] = in[r][(c-off[r]+NB) mod NB].
- The mod is evaluated at elaboration; no runtime arithmetic.
- Transform is applied on the input side; the result is written into the buffer together with in_tag.
- Transfer in occurs when in_valid && in_ready. Transfer out occurs when out_valid && out_ready.
- Buffer FSM, states EMPTY / ONE / FULL:
  - EMPTY: in fire -> ONE.
  - ONE: in fire only -> FULL; out fire only -> EMPTY; both -> ONE (new entry replaces head).
  - FULL: out fire -> ONE (skid entry becomes head); in_ready=0, so no in fire.
- in_ready = (state != FULL), registered.
- out_valid = (state != EMPTY).
- out_state and out_tag always present the oldest entry.
- Latency: 1 cycle from in fire to out_valid when the stage is EMPTY.
- Throughput: 1 transfer/cycle while out_ready stays high.
- Order is strictly FIFO; no entry is dropped or duplicated.
- Output stability: while out_valid && !out_ready, out_state and out_tag are held stable.
- in_inverse and in_tag are sampled only on in fire.
- Reset, at any time including mid-transfer:
  - FSM -> EMPTY; out_valid=0; in_ready=1 on the cycle after reset deasserts; in_ready=0 while rst=1.
  - out_state=0, out_tag=0, blk_count=0.
  - Buffered data is discarded.
- Inputs are ignored while rst=1.
- Simultaneous in/out fire in ONE is legal and must not stall.

Optional Feature:
- Macro: SHIFT_ROWS_PIPE_STATS_EN.
- When defined:
  - blk_count port exists and increments by 1 on each out fire.
  - Wraps modulo 2^CNT_W.
  - Cleared by rst.
- When undefined:
  - blk_count port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- NB=4, forward, state bytes (stream order) d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 (FIPS-197 round 1), out_ready=1 -> one cycle later out_valid=1, out_state = d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5.
- Same FIPS-197 round 1 output fed back with in_inverse=1 -> original d4 27 11 ae ... 52 30 returned. Repeat the round trip for NB=6 and NB=8 with random states; forward-then-inverse must be identity.
- NB=8, byte (r,c) = 8'h(r*16+c), forward -> row 2 reads 23 24 25 26 27 20 21 22; row 3 reads 34 35 36 37 30 31 32 33.
- Backpressure:
  - Stream tags 0..9 back-to-back with out_ready low for cycles 3-6.
  - in_ready falls exactly when 2 entries are held.
  - Outputs hold stable while stalled.
  - Tags emerge 0..9 in order, none lost.
- Steady stream with out_ready=1 -> one transfer per cycle and in_ready never drops. Assert rst mid-stream with FULL buffer -> next cycle out_valid=0, blk_count=0, no stale tag emitted after release.
- STATS_EN build: 300 transfers with CNT_W=8 -> blk_count = 44 (300 mod 256).
